// File: rtl/ro_row_sequencer.sv
// Readout row sequencer: answers the exposure trigger/busy handshake and walks rows 0..NUM_ROW-1,
// driving row select, reset/signal sample strobes and the per-row ADC start.
module ro_row_sequencer #(
  parameter int unsigned ROW_W = 9,
  parameter int unsigned TS_W  = 8,
  parameter int unsigned TA_W  = 12
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [ROW_W-1:0] NUM_ROW,
  input  logic [TS_W-1:0]  T_ROWSET,
  input  logic [TS_W-1:0]  T_SAMP,
  input  logic [TA_W-1:0]  T_ADC,
  input  logic             trigger_i,
  output logic             re_busy,
  output logic [ROW_W-1:0] ROWADD,
  output logic             ROW_SEL,
  output logic             SAMP_RST,
  output logic             SAMP_SIG,
  output logic             ADC_START,
  output logic             row_done,
  output logic             frame_done,
  output logic             overrun
);

  localparam int unsigned CW = (TS_W > TA_W) ? TS_W : TA_W;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] SAMP_R = 3'd2;
  localparam logic [2:0] SAMP_S = 3'd3;
  localparam logic [2:0] CONV   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] num_q;
  logic [TS_W-1:0]  a_m1_q, b_m1_q;
  logic [TA_W-1:0]  c_m1_q;
  logic             overrun_q;
  logic             busy_q, sel_q, srst_q, ssig_q, adc_q;

  // Counters hold (duration - 1); a programmed 0 behaves like 1.
  logic [TS_W-1:0]  a_m1_in, b_m1_in;
  logic [TA_W-1:0]  c_m1_in;
  assign a_m1_in = (T_ROWSET == '0) ? '0 : T_ROWSET - TS_W'(1);
  assign b_m1_in = (T_SAMP == '0) ? '0 : T_SAMP - TS_W'(1);
  assign c_m1_in = (T_ADC == '0) ? '0 : T_ADC - TA_W'(1);

  logic accept, last_cnt, last_row;
  assign accept   = (state_q == IDLE) && trigger_i && (NUM_ROW != '0);
  assign last_cnt = (cnt_q == '0);
  assign last_row = (row_q == num_q - ROW_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    if (state_q != IDLE && !last_cnt) begin
      cnt_d = cnt_q - CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETTLE;
          cnt_d   = CW'(a_m1_in);
          row_d   = '0;
        end
      end
      SETTLE: begin
        if (last_cnt) begin
          state_d = SAMP_R;
          cnt_d   = CW'(b_m1_q);
        end
      end
      SAMP_R: begin
        if (last_cnt) begin
          state_d = SAMP_S;
          cnt_d   = CW'(b_m1_q);
        end
      end
      SAMP_S: begin
        if (last_cnt) begin
          state_d = CONV;
          cnt_d   = CW'(c_m1_q);
        end
      end
      CONV: begin
        if (last_cnt) begin
          if (last_row) begin
            state_d = IDLE;
            cnt_d   = '0;
            row_d   = '0;
          end else begin
            state_d = SETTLE;
            cnt_d   = CW'(a_m1_q);
            row_d   = row_q + ROW_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Level outputs are registered from the next state so they never glitch across transitions.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      row_q     <= '0;
      num_q     <= '0;
      a_m1_q    <= '0;
      b_m1_q    <= '0;
      c_m1_q    <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= 1'b0;
      srst_q    <= 1'b0;
      ssig_q    <= 1'b0;
      adc_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      if (accept) begin
        num_q  <= NUM_ROW;
        a_m1_q <= a_m1_in;
        b_m1_q <= b_m1_in;
        c_m1_q <= c_m1_in;
      end
      if (state_q != IDLE && trigger_i) begin
        overrun_q <= 1'b1;
      end
      busy_q <= (state_d != IDLE);
      sel_q  <= (state_d == SETTLE) || (state_d == SAMP_R) || (state_d == SAMP_S);
      srst_q <= (state_d == SAMP_R);
      ssig_q <= (state_d == SAMP_S);
      adc_q  <= (state_d == CONV) && (state_q != CONV);
    end
  end

  assign re_busy    = busy_q;
  assign ROWADD     = row_q;
  assign ROW_SEL    = sel_q;
  assign SAMP_RST   = srst_q;
  assign SAMP_SIG   = ssig_q;
  assign ADC_START  = adc_q;
  assign row_done   = (state_q == CONV) && last_cnt;
  assign frame_done = row_done && last_row;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ro_row_sequencer.sv
// Self-checking bench for ro_row_sequencer: table-driven frame vectors plus directed corner cases.
module tb_ro_row_sequencer;

  logic        CLK = 1'b0;
  logic        rst;
  logic [8:0]  NUM_ROW;
  logic [7:0]  T_ROWSET;
  logic [7:0]  T_SAMP;
  logic [11:0] T_ADC;
  logic        trigger_i;
  logic        re_busy;
  logic [8:0]  ROWADD;
  logic        ROW_SEL, SAMP_RST, SAMP_SIG, ADC_START, row_done, frame_done, overrun;

  ro_row_sequencer dut (
    .CLK       (CLK),
    .rst       (rst),
    .NUM_ROW   (NUM_ROW),
    .T_ROWSET  (T_ROWSET),
    .T_SAMP    (T_SAMP),
    .T_ADC     (T_ADC),
    .trigger_i (trigger_i),
    .re_busy   (re_busy),
    .ROWADD    (ROWADD),
    .ROW_SEL   (ROW_SEL),
    .SAMP_RST  (SAMP_RST),
    .SAMP_SIG  (SAMP_SIG),
    .ADC_START (ADC_START),
    .row_done  (row_done),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int num;
    int t_rowset;
    int t_samp;
    int t_adc;
    int exp_busy;
    int exp_row_len;
    int exp_rows;
    int exp_last;
  } vec_t;

  vec_t vecs[6];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int outs();
    return {24'd0, re_busy, ROW_SEL, SAMP_RST, SAMP_SIG, ADC_START, row_done, frame_done, overrun};
  endfunction

  task automatic set_cfg(input int num, input int ts, input int sp, input int ad);
    NUM_ROW  = num[8:0];
    T_ROWSET = ts[7:0];
    T_SAMP   = sp[7:0];
    T_ADC    = ad[11:0];
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (re_busy && g < 10000) begin
      step();
      g++;
    end
    check(name, re_busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic run_frame(input vec_t v);
    int busy, rd, fd, last, inrow, badlen, badseq, badco, g;
    set_cfg(v.num, v.t_rowset, v.t_samp, v.t_adc);
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    // Later input changes must not affect the running frame.
    set_cfg(7, 9, 9, 9);
    check("busy_latency", re_busy, 1);
    busy = 0; rd = 0; fd = 0; last = -1; inrow = 0; badlen = 0; badseq = 0; badco = 0; g = 0;
    while (re_busy && g < 20000) begin
      busy++;
      inrow++;
      if (row_done) begin
        if (inrow != v.exp_row_len) badlen++;
        if (int'(ROWADD) != rd) badseq++;
        rd++;
        inrow = 0;
      end
      if (frame_done) begin
        fd++;
        last = int'(ROWADD);
        if (!row_done) badco++;
      end
      step();
      g++;
    end
    check("busy_cycles", busy, v.exp_busy);
    check("row_done_count", rd, v.exp_rows);
    check("frame_done_count", fd, 1);
    check("last_rowadd", last, v.exp_last);
    check("row_len_errors", badlen + badseq + badco, 0);
    check("rowadd_after_frame", int'(ROWADD), 0);
    check("overrun_clear", overrun, 0);
  endtask

  initial begin
    int busy, g, act, exp, acc;
    logic [9:0] seq;

    vecs[0] = '{4, 2, 3, 5, 52, 13, 4, 3};
    vecs[1] = '{3, 0, 0, 0, 12, 4, 3, 2};
    vecs[2] = '{1, 1, 1, 1, 4, 4, 1, 0};
    vecs[3] = '{2, 1, 2, 3, 16, 8, 2, 1};
    vecs[4] = '{1, 255, 255, 4095, 4860, 4860, 1, 0};
    vecs[5] = '{176, 2, 3, 5, 2288, 13, 176, 175};

    rst = 1'b0;
    trigger_i = 1'b0;
    set_cfg(0, 0, 0, 0);
    step();
    step();
    check("reset_outputs", outs(), 0);
    check("reset_rowadd", int'(ROWADD), 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i]);
      step();
    end

    // Per-row strobe pattern for a=2, b=3, c=5.
    set_cfg(4, 2, 3, 5);
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    for (int i = 0; i < 13; i++) begin
      exp = {27'd0, i < 8, i >= 2 && i < 5, i >= 5 && i < 8, i == 8, i == 12};
      act = {27'd0, ROW_SEL, SAMP_RST, SAMP_SIG, ADC_START, row_done};
      check($sformatf("row0_strobes_c%0d", i), act, exp);
      step();
    end
    check("row1_rowadd", int'(ROWADD), 1);
    wait_idle("strobe_frame_end");
    step();

    // Retrigger while busy, with NUM_ROW changed.
    set_cfg(4, 2, 3, 5);
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    busy = 1;
    g = 0;
    while (re_busy && g < 1000) begin
      if (busy == 10) begin
        trigger_i = 1'b1;
        NUM_ROW = 9'd2;
      end
      step();
      if (busy == 10) begin
        check("overrun_set", overrun, 1);
        trigger_i = 1'b0;
      end
      if (re_busy) busy++;
      g++;
    end
    check("overrun_frame_len", busy, 52);
    step();
    step();
    check("overrun_sticky", overrun, 1);
    do_reset();
    step();
    check("overrun_reset", overrun, 0);

    // Reset mid-frame aborts without frame_done.
    set_cfg(4, 2, 3, 5);
    trigger_i = 1'b1;
    step();
    trigger_i = 1'b0;
    busy = 1;
    while (busy < 20) begin
      step();
      busy++;
    end
    rst = 1'b0;
    step();
    check("midframe_reset_outputs", outs(), 0);
    check("midframe_reset_rowadd", int'(ROWADD), 0);
    rst = 1'b1;
    step();
    run_frame(vecs[0]);
    step();

    // NUM_ROW=0 ignores trigger.
    set_cfg(0, 2, 3, 5);
    trigger_i = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      acc = acc | outs();
    end
    trigger_i = 1'b0;
    check("num_row_zero_quiet", acc, 0);

    // Trigger held through frame end restarts after one idle cycle.
    set_cfg(1, 1, 1, 1);
    trigger_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      seq[9-i] = re_busy;
    end
    trigger_i = 1'b0;
    check("held_trigger_busy_seq", int'(seq), int'(10'b1111011110));
    check("held_trigger_overrun", overrun, 1);
    wait_idle("held_trigger_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
